reset_sequencer: RTL and testbench

//  Releases NUM_STAGES downstream reset domains in strict order: stage 0 first, then 1, then 2, and so on.
//  Its inputs are the filtered reset requests (primary and aux) from the reset controller.

---
 rtl/reset_seq_pkg.sv | 24 ++
 rtl/reset_seq_if.sv | 25 ++
 rtl/reset_seq_timer.sv | 29 ++
 rtl/reset_sequencer.sv | 170 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the ordered reset-release sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } seq_state_e;

  localparam int DEF_NUM_STAGES  = 3;
  localparam int DEF_HOLD_CYCLES = 5;
  localparam int DEF_GAP_CYCLES  = 5;
  localparam int DEF_ACK_TIMEOUT = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// Request/ack/reset bundle between the reset controller, the sequencer and the domains.
interface reset_seq_if #(
  parameter int NUM_STAGES = 3
);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic                  i_rst_req;
  logic                  i_aux_rst_req;
  logic [NUM_STAGES-1:0] i_stage_ack;
  logic [NUM_STAGES-1:0] o_rst;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_timeout_err;
  logic [IW-1:0]         o_stage_idx;

  modport master (
    output i_rst_req, i_aux_rst_req, i_stage_ack,
    input  o_rst, o_busy, o_done, o_timeout_err, o_stage_idx
  );

  modport slave (
    input  i_rst_req, i_aux_rst_req, i_stage_ack,
    output o_rst, o_busy, o_done, o_timeout_err, o_stage_idx
  );
endinterface

// File: rtl/reset_seq_timer.sv
// Loadable saturating down-counter; last is high while the count is at its final step.
module reset_seq_timer #(
  parameter int W       = 5,
  parameter int RST_VAL = 1
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= W'(RST_VAL);
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  // A phase of length L is loaded with L, so the L-th decrementing edge sees 1.
  assign last = (cnt_reg <= W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases downstream reset domains one at a time, waiting for each domain's ack.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input logic        clk,
  input logic        i_rst,
  reset_seq_if.slave bus
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CW = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, ACK_TIMEOUT) + 1);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] AUX_MASK = {{(NUM_STAGES-1){1'b1}}, 1'b0};
  localparam logic [CW-1:0]         HOLD_LD  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]         GAP_LD   = CW'(GAP_CYCLES);
  localparam logic [CW-1:0]         ACK_LD   = CW'(ACK_TIMEOUT);

  seq_state_e            state_reg, state_next;
  logic [NUM_STAGES-1:0] rst_reg, rst_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic [IW-1:0]         idx_reg, idx_next;
  logic [IW-1:0]         start_reg, start_next;

  logic                  t_load, t_dec, t_last;
  logic [CW-1:0]         t_val;
  logic [NUM_STAGES-1:0] ack_hit;
  logic                  ack_now;
  logic                  stage0_pending;
  logic [IW-1:0]         idx_inc;

  // Only the ack of the stage being awaited counts.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_ack
      assign ack_hit[gi] = bus.i_stage_ack[gi] && (idx_reg == IW'(gi));
    end
  endgenerate

  assign ack_now = |ack_hit;
  assign idx_inc = idx_reg + IW'(1);
  assign stage0_pending = ((state_reg == ST_HOLD) && (start_reg == '0)) ||
                          ((state_reg == ST_WAIT_ACK) && (idx_reg == '0));

  reset_seq_timer #(
    .W       (CW),
    .RST_VAL (HOLD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .srst     (i_rst),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .last     (t_last)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= ST_HOLD;
      rst_reg   <= '1;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      idx_reg   <= '0;
      start_reg <= '0;
    end else begin
      state_reg <= state_next;
      rst_reg   <= rst_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      idx_reg   <= idx_next;
      start_reg <= start_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rst_next   = rst_reg;
    busy_next  = busy_reg;
    done_next  = done_reg;
    err_next   = err_reg;
    idx_next   = idx_reg;
    start_next = start_reg;
    t_load     = 1'b0;
    t_dec      = 1'b0;
    t_val      = HOLD_LD;

    // Requests take priority over every state transition.
    if (bus.i_rst_req || (bus.i_aux_rst_req && stage0_pending)) begin
      state_next = ST_HOLD;
      rst_next   = '1;
      start_next = '0;
      busy_next  = 1'b1;
      done_next  = 1'b0;
      t_load     = 1'b1;
    end else if (bus.i_aux_rst_req) begin
      state_next = ST_HOLD;
      rst_next   = rst_reg | AUX_MASK;
      start_next = IW'(1);
      busy_next  = 1'b1;
      done_next  = 1'b0;
      t_load     = 1'b1;
    end else begin
      unique case (state_reg)
        ST_HOLD: begin
          t_dec = 1'b1;
          if (t_last) begin
            rst_next[start_reg] = 1'b0;
            idx_next   = start_reg;
            state_next = ST_WAIT_ACK;
            t_load     = 1'b1;
            t_val      = ACK_LD;
          end
        end
        ST_WAIT_ACK: begin
          if (ack_now) begin
            if (idx_reg == LAST_IDX) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
              busy_next  = 1'b0;
            end else begin
              state_next = ST_GAP;
              t_load     = 1'b1;
              t_val      = GAP_LD;
            end
          end else begin
            t_dec = 1'b1;
            if (t_last) begin
              state_next = ST_HOLD;
              rst_next   = '1;
              err_next   = 1'b1;
              start_next = '0;
              t_load     = 1'b1;
            end
          end
        end
        ST_GAP: begin
          t_dec = 1'b1;
          if (t_last) begin
            rst_next[idx_inc] = 1'b0;
            idx_next   = idx_inc;
            state_next = ST_WAIT_ACK;
            t_load     = 1'b1;
            t_val      = ACK_LD;
          end
        end
        ST_DONE: begin
          rst_next = '0;
        end
        default: begin
          state_next = ST_HOLD;
        end
      endcase
    end
  end

  assign bus.o_rst         = rst_reg;
  assign bus.o_busy        = busy_reg;
  assign bus.o_done        = done_reg;
  assign bus.o_timeout_err = err_reg;
  assign bus.o_stage_idx   = idx_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a per-stage ack model (ack rises 2 cycles after release).
module tb_reset_sequencer;

  logic clk;
  logic i_rst;
  int   n_asserts;
  int   n_fail;
  int   age [3];
  logic [2:0] ack_block;
  logic [2:0] ack_force;
  int   cyc;

  reset_seq_if #(.NUM_STAGES(3)) bus ();

  reset_sequencer #(
    .NUM_STAGES  (3),
    .HOLD_CYCLES (5),
    .GAP_CYCLES  (5),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk   (clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h", tag, got);
    end
  endtask

  task automatic drive_ack();
    for (int i = 0; i < 3; i++) begin
      bus.i_stage_ack[i] = ((age[i] >= 2) && !ack_block[i]) || ack_force[i];
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (bus.o_rst[i]) age[i] = 0;
        else if (age[i] < 1000) age[i] = age[i] + 1;
      end
      drive_ack();
    end
  endtask

  task automatic run_to_done(input int budget, output int c);
    c = 0;
    while ((bus.o_done !== 1'b1) && (c < budget)) begin
      tick(1);
      c++;
    end
  endtask

  task automatic pulse_primary();
    bus.i_rst_req = 1'b1;
    tick(1);
    check_eq("prim_rst", {29'd0, bus.o_rst}, 32'h7);
    bus.i_rst_req = 1'b0;
  endtask

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    for (int i = 0; i < 3; i++) age[i] = 0;
    ack_block = 3'b000;
    ack_force = 3'b000;
    i_rst = 1'b1;
    bus.i_rst_req     = 1'b0;
    bus.i_aux_rst_req = 1'b0;
    bus.i_stage_ack   = 3'b000;

    // Reset state
    tick(2);
    check_eq("rst_o_rst", {29'd0, bus.o_rst}, 32'h7);
    check_eq("rst_busy", {31'd0, bus.o_busy}, 32'h1);
    check_eq("rst_done", {31'd0, bus.o_done}, 32'h0);
    check_eq("rst_err", {31'd0, bus.o_timeout_err}, 32'h0);
    check_eq("rst_idx", {30'd0, bus.o_stage_idx}, 32'h0);
    i_rst = 1'b0;

    // 1: plain power-up sequence
    tick(4);
    check_eq("t1_e4", {29'd0, bus.o_rst}, 32'h7);
    tick(1);
    check_eq("t1_e5", {29'd0, bus.o_rst}, 32'h6);
    check_eq("t1_idx0", {30'd0, bus.o_stage_idx}, 32'h0);
    tick(6);
    check_eq("t1_e11", {29'd0, bus.o_rst}, 32'h6);
    tick(1);
    check_eq("t1_e12", {29'd0, bus.o_rst}, 32'h4);
    check_eq("t1_idx1", {30'd0, bus.o_stage_idx}, 32'h1);
    tick(7);
    check_eq("t1_e19", {29'd0, bus.o_rst}, 32'h0);
    check_eq("t1_idx2", {30'd0, bus.o_stage_idx}, 32'h2);
    check_eq("t1_e19_done", {31'd0, bus.o_done}, 32'h0);
    tick(2);
    check_eq("t1_done", {31'd0, bus.o_done}, 32'h1);
    check_eq("t1_busy", {31'd0, bus.o_busy}, 32'h0);

    // 2: primary request interrupts the hold count
    pulse_primary();
    check_eq("t2_done_clr", {31'd0, bus.o_done}, 32'h0);
    check_eq("t2_busy_set", {31'd0, bus.o_busy}, 32'h1);
    tick(3);
    bus.i_rst_req = 1'b1;
    tick(1);
    bus.i_rst_req = 1'b0;
    tick(4);
    check_eq("t2_low4", {29'd0, bus.o_rst}, 32'h7);
    tick(1);
    check_eq("t2_low5", {29'd0, bus.o_rst}, 32'h6);
    run_to_done(60, cyc);
    check_eq("t2_done_lat", cyc, 32'd16);

    // 3: aux request from DONE keeps stage 0 released
    bus.i_aux_rst_req = 1'b1;
    tick(1);
    check_eq("t3_aux_rst", {29'd0, bus.o_rst}, 32'h6);
    check_eq("t3_aux_done", {31'd0, bus.o_done}, 32'h0);
    tick(3);
    check_eq("t3_aux_held", {29'd0, bus.o_rst}, 32'h6);
    bus.i_aux_rst_req = 1'b0;
    tick(4);
    check_eq("t3_low4", {29'd0, bus.o_rst}, 32'h6);
    tick(1);
    check_eq("t3_low5", {29'd0, bus.o_rst}, 32'h4);
    check_eq("t3_idx1", {30'd0, bus.o_stage_idx}, 32'h1);
    run_to_done(60, cyc);
    check_eq("t3_done_lat", cyc, 32'd9);
    check_eq("t3_final_rst", {29'd0, bus.o_rst}, 32'h0);

    // 4: stage 1 never acks -> timeout and retry
    pulse_primary();
    ack_block[1] = 1'b1;
    tick(5);
    check_eq("t4_s0_rel", {29'd0, bus.o_rst}, 32'h6);
    tick(7);
    check_eq("t4_s1_rel", {29'd0, bus.o_rst}, 32'h4);
    tick(15);
    check_eq("t4_pre_to", {29'd0, bus.o_rst}, 32'h4);
    check_eq("t4_pre_err", {31'd0, bus.o_timeout_err}, 32'h0);
    tick(1);
    check_eq("t4_to_rst", {29'd0, bus.o_rst}, 32'h7);
    check_eq("t4_to_err", {31'd0, bus.o_timeout_err}, 32'h1);
    ack_block[1] = 1'b0;
    run_to_done(80, cyc);
    check_eq("t4_retry_lat", cyc, 32'd21);
    check_eq("t4_err_sticky", {31'd0, bus.o_timeout_err}, 32'h1);

    // 5: both requests during GAP -> full restart from stage 0
    pulse_primary();
    tick(8);
    check_eq("t5_in_gap", {29'd0, bus.o_rst}, 32'h6);
    bus.i_rst_req     = 1'b1;
    bus.i_aux_rst_req = 1'b1;
    tick(1);
    check_eq("t5_both_rst", {29'd0, bus.o_rst}, 32'h7);
    bus.i_rst_req     = 1'b0;
    bus.i_aux_rst_req = 1'b0;
    tick(4);
    check_eq("t5_low4", {29'd0, bus.o_rst}, 32'h7);
    tick(1);
    check_eq("t5_low5", {29'd0, bus.o_rst}, 32'h6);
    run_to_done(60, cyc);
    check_eq("t5_done_lat", cyc, 32'd16);
    check_eq("t5_err_sticky", {31'd0, bus.o_timeout_err}, 32'h1);
    i_rst = 1'b1;
    tick(1);
    check_eq("t5_err_clr", {31'd0, bus.o_timeout_err}, 32'h0);
    check_eq("t5_rst_all", {29'd0, bus.o_rst}, 32'h7);

    // 6: ack on the timeout edge wins; stray stage-2 ack ignored
    ack_block[0] = 1'b1;
    ack_force[2] = 1'b1;
    drive_ack();
    i_rst = 1'b0;
    tick(20);
    check_eq("t6_e20_rst", {29'd0, bus.o_rst}, 32'h6);
    check_eq("t6_e20_idx", {30'd0, bus.o_stage_idx}, 32'h0);
    check_eq("t6_e20_err", {31'd0, bus.o_timeout_err}, 32'h0);
    ack_force[0] = 1'b1;
    ack_force[2] = 1'b0;
    drive_ack();
    tick(1);
    check_eq("t6_e21_rst", {29'd0, bus.o_rst}, 32'h6);
    check_eq("t6_e21_err", {31'd0, bus.o_timeout_err}, 32'h0);
    tick(4);
    check_eq("t6_gap4", {29'd0, bus.o_rst}, 32'h6);
    tick(1);
    check_eq("t6_gap5", {29'd0, bus.o_rst}, 32'h4);
    ack_block[0] = 1'b0;
    ack_force[0] = 1'b0;
    drive_ack();
    run_to_done(60, cyc);
    check_eq("t6_done_lat", cyc, 32'd9);
    check_eq("t6_err_none", {31'd0, bus.o_timeout_err}, 32'h0);

    // 7: aux while stage 0 awaits its ack behaves like a primary request
    pulse_primary();
    tick(5);
    check_eq("t7_s0_rel", {29'd0, bus.o_rst}, 32'h6);
    bus.i_aux_rst_req = 1'b1;
    tick(1);
    check_eq("t7_aux_prim", {29'd0, bus.o_rst}, 32'h7);
    bus.i_aux_rst_req = 1'b0;
    tick(4);
    check_eq("t7_low4", {29'd0, bus.o_rst}, 32'h7);
    tick(1);
    check_eq("t7_low5", {29'd0, bus.o_rst}, 32'h6);
    run_to_done(60, cyc);
    check_eq("t7_done_lat", cyc, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
